// File: rtl/wb_stage.sv
// wb_stage: rv32 writeback stage. Writes retired results to the register file,
// counts retired instructions, and turns memory-stage exceptions into a held trap
// request followed by a one-cycle flush pulse.
// Latency: 1 cycle from transfer to rf write or trap_req_o.
// Backpressure: mem_ready_o is low while a trap is pending or flushing, and during reset.
// Ports: mem_* carry the incoming record (valid/ready), rf_* drive the register-file
// write port, trap_*/flush_o talk to the CSR/trap unit and the upstream stages, and
// instret_o is the 64-bit retired-instruction counter.
module wb_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  mem_valid_i,
    output logic                  mem_ready_o,
    input  logic [ADDR_WIDTH-1:0] mem_pc_i,
    input  logic                  mem_rd_we_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_wb_data_i,
    input  logic                  mem_exception_i,
    input  logic [1:0]            mem_exception_type_i,
    input  logic [ADDR_WIDTH-1:0] mem_fault_addr_i,
    output logic                  rf_we_o,
    output logic [REG_ADDR_W-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic                  trap_req_o,
    output logic [1:0]            trap_cause_o,
    output logic [ADDR_WIDTH-1:0] trap_pc_o,
    output logic [ADDR_WIDTH-1:0] trap_tval_o,
    input  logic                  trap_ack_i,
    output logic                  flush_o,
    output logic [63:0]           instret_o
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        TRAP  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0]   rf_wdata_q, rf_wdata_d;
    logic                    trap_req_q, trap_req_d;
    logic [1:0]              trap_cause_q, trap_cause_d;
    logic [ADDR_WIDTH-1:0]   trap_pc_q, trap_pc_d;
    logic [ADDR_WIDTH-1:0]   trap_tval_q, trap_tval_d;
    logic                    flush_q, flush_d;
    logic [63:0]             instret_q, instret_d;
    logic                    xfer;

    // Ready is the only combinational output; gating with rst_ni keeps the
    // upstream stage from handing over a record that reset would swallow.
    assign mem_ready_o = rst_ni && (state_q == RUN);
    assign xfer        = mem_valid_i && mem_ready_o;

    always_comb begin
        state_d      = state_q;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        trap_req_d   = trap_req_q;
        trap_cause_d = trap_cause_q;
        trap_pc_d    = trap_pc_q;
        trap_tval_d  = trap_tval_q;
        flush_d      = 1'b0;
        instret_d    = instret_q;

        unique case (state_q)
            RUN: begin
                if (xfer) begin
                    if (mem_exception_i) begin
                        // Exception wins over any rd write and does not retire.
                        state_d      = TRAP;
                        trap_req_d   = 1'b1;
                        trap_cause_d = mem_exception_type_i;
                        trap_pc_d    = mem_pc_i;
                        trap_tval_d  = mem_fault_addr_i;
                    end else begin
                        // x0 is never written but the record still retires.
                        rf_we_d    = mem_rd_we_i && (mem_rd_addr_i != '0);
                        rf_waddr_d = mem_rd_addr_i;
                        rf_wdata_d = mem_wb_data_i;
                        instret_d  = instret_q + 64'd1;
                    end
                end
            end
            TRAP: begin
                if (trap_ack_i) begin
                    state_d    = FLUSH;
                    trap_req_d = 1'b0;
                    flush_d    = 1'b1;
                end
            end
            FLUSH: begin
                state_d = RUN;
            end
            default: begin
                state_d    = RUN;
                trap_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= RUN;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            trap_req_q   <= 1'b0;
            trap_cause_q <= 2'b00;
            trap_pc_q    <= '0;
            trap_tval_q  <= '0;
            flush_q      <= 1'b0;
            instret_q    <= 64'd0;
        end else begin
            state_q      <= state_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            trap_req_q   <= trap_req_d;
            trap_cause_q <= trap_cause_d;
            trap_pc_q    <= trap_pc_d;
            trap_tval_q  <= trap_tval_d;
            flush_q      <= flush_d;
            instret_q    <= instret_d;
        end
    end

    assign rf_we_o      = rf_we_q;
    assign rf_waddr_o   = rf_waddr_q;
    assign rf_wdata_o   = rf_wdata_q;
    assign trap_req_o   = trap_req_q;
    assign trap_cause_o = trap_cause_q;
    assign trap_pc_o    = trap_pc_q;
    assign trap_tval_o  = trap_tval_q;
    assign flush_o      = flush_q;
    assign instret_o    = instret_q;

endmodule
